// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: synchronizes chip select and byte-ready, decodes
// a command byte then writes data bytes into an auto-incrementing register bank.
module spi_reg_ctrl #(
  parameter int                   DATAWIDTH = 8,
  parameter int                   NREGS     = 4,
  parameter int                   ADDRW     = 2,
  parameter logic [DATAWIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       nsel,
  input  logic [DATAWIDTH-1:0]       spi_data,
  input  logic                       spi_data_rdy,
  output logic [NREGS*DATAWIDTH-1:0] regs,
  output logic                       wr_stb,
  output logic [ADDRW-1:0]           wr_addr,
  output logic                       frame_err,
  output logic [7:0]                 wr_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   nsel_meta_q, nsel_s_q;
  logic                   rdy_meta_q, rdy_s_q, rdy_prev_q;
  logic [ADDRW-1:0]       ptr_q;
  logic [ADDRW-1:0]       ptr_d;
  logic [DATAWIDTH-1:0]   regs_q [NREGS];
  logic                   wr_stb_q;
  logic [ADDRW-1:0]       wr_addr_q;
  logic                   frame_err_q;
  logic [7:0]             wr_count_q;
  logic                   byte_stb_s;

  // Two-flop synchronizers plus a delayed copy of ready for edge detection.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nsel_meta_q <= 1'b1;
      nsel_s_q    <= 1'b1;
      rdy_meta_q  <= 1'b0;
      rdy_s_q     <= 1'b0;
      rdy_prev_q  <= 1'b0;
    end else begin
      nsel_meta_q <= nsel;
      nsel_s_q    <= nsel_meta_q;
      rdy_meta_q  <= spi_data_rdy;
      rdy_s_q     <= rdy_meta_q;
      rdy_prev_q  <= rdy_s_q;
    end
  end

  // Byte strobe on the synchronized ready rising edge; next write pointer.
  always_comb begin
    byte_stb_s = rdy_s_q & ~rdy_prev_q;
    ptr_d      = ptr_q + ADDRW'(1);
  end

  // Frame sequencer and register-bank write path.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      wr_count_q  <= 8'd0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      wr_stb_q <= 1'b0;
      // Deselect has priority over any byte arriving in the same cycle.
      if (nsel_s_q) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Ready already high at frame start means a byte straddles frames.
            if (rdy_s_q) begin
              state_q     <= ST_DISCARD;
              frame_err_q <= 1'b1;
            end else begin
              state_q     <= ST_CMD;
              frame_err_q <= 1'b0;
            end
          end
          ST_CMD: begin
            if (byte_stb_s) begin
              if (spi_data[DATAWIDTH-1]) begin
                ptr_q   <= spi_data[ADDRW-1:0];
                state_q <= ST_DATA;
              end else begin
                state_q <= ST_DISCARD;
              end
            end
          end
          ST_DATA: begin
            if (byte_stb_s) begin
              regs_q[ptr_q] <= spi_data;
              wr_stb_q      <= 1'b1;
              wr_addr_q     <= ptr_q;
              wr_count_q    <= wr_count_q + 8'd1;
              ptr_q         <= ptr_d;
            end
          end
          ST_DISCARD: begin
            state_q <= ST_DISCARD;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Flatten the bank onto the output bus.
  always_comb begin
    regs = '0;
    for (int i = 0; i < NREGS; i++) begin
      regs[i*DATAWIDTH +: DATAWIDTH] = regs_q[i];
    end
  end

  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: table-driven frames, randomized frames
// against a frame-level model, and hand-written abort/stale/reset sequences.
module tb_spi_reg_ctrl;

  logic        clk;
  logic        nreset;
  logic        nsel;
  logic [7:0]  spi_data;
  logic        spi_data_rdy;
  logic [31:0] regs;
  logic        wr_stb;
  logic [1:0]  wr_addr;
  logic        frame_err;
  logic [7:0]  wr_count;

  int tests;
  int fails;
  int stb_cnt;
  logic prev_stb;

  logic [7:0] m_regs [4];
  logic [7:0] m_count;
  logic [1:0] m_addr;

  typedef struct {
    logic [7:0]  cmd;
    int          n;
    logic [47:0] data;
    logic [31:0] exp_regs;
    logic [7:0]  exp_count;
    int          exp_stbs;
  } vec_t;

  vec_t vecs [6];

  spi_reg_ctrl dut (
    .clk          (clk),
    .nreset       (nreset),
    .nsel         (nsel),
    .spi_data     (spi_data),
    .spi_data_rdy (spi_data_rdy),
    .regs         (regs),
    .wr_stb       (wr_stb),
    .wr_addr      (wr_addr),
    .frame_err    (frame_err),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts write strobes and flags back-to-back pulses.
  always @(negedge clk) begin
    if (nreset) begin
      if (wr_stb) begin
        stb_cnt++;
        check("stb_back_to_back", 64'(prev_stb), 64'(0));
      end
      prev_stb = wr_stb;
    end else begin
      prev_stb = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_data     = b;
    spi_data_rdy = 1'b1;
    tick(4);
    spi_data_rdy = 1'b0;
    tick(3);
  endtask

  task automatic model_frame(input logic [7:0] cmd, input int n, input logic [47:0] d);
    if (cmd[7]) begin
      for (int k = 0; k < n; k++) begin
        int a;
        a = (int'(cmd[1:0]) + k) % 4;
        m_regs[a] = d[k*8 +: 8];
        m_addr    = 2'(a);
        m_count   = m_count + 8'd1;
      end
    end
  endtask

  task automatic drive_frame(input logic [7:0] cmd, input int n, input logic [47:0] d,
                             output int stbs);
    int s0;
    s0   = stb_cnt;
    nsel = 1'b0;
    tick(4);
    send_byte(cmd);
    for (int k = 0; k < n; k++) send_byte(d[k*8 +: 8]);
    tick(2);
    nsel = 1'b1;
    tick(4);
    stbs = stb_cnt - s0;
    model_frame(cmd, n, d);
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_reg%0d", tag, i), 64'(regs[i*8 +: 8]), 64'(m_regs[i]));
    end
    check({tag, "_count"}, 64'(wr_count), 64'(m_count));
    check({tag, "_addr"}, 64'(wr_addr), 64'(m_addr));
  endtask

  initial begin
    int stbs;
    int s0;
    logic [7:0]  cmd;
    logic [47:0] d;
    int n;
    bit seen;

    tests = 0; fails = 0; stb_cnt = 0; prev_stb = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_count = 8'd0; m_addr = 2'd0;

    vecs[0] = '{8'h83, 3, 48'h0000_0033_2211, 32'h1100_3322, 8'd4,  3};
    vecs[1] = '{8'h02, 1, 48'h0000_0000_0055, 32'h1100_3322, 8'd4,  0};
    vecs[2] = '{8'h80, 0, 48'h0000_0000_0000, 32'h1100_3322, 8'd4,  0};
    vecs[3] = '{8'hFE, 2, 48'h0000_0000_BBAA, 32'hBBAA_3322, 8'd6,  2};
    vecs[4] = '{8'h81, 5, 48'h0005_0403_0201, 32'h0302_0504, 8'd11, 5};
    vecs[5] = '{8'h7F, 1, 48'h0000_0000_00EE, 32'h0302_0504, 8'd11, 0};

    nreset = 1'b0; nsel = 1'b1; spi_data = 8'h00; spi_data_rdy = 1'b0;
    tick(3);
    check("rst_regs", 64'(regs), 64'(0));
    check("rst_stb", 64'(wr_stb), 64'(0));
    check("rst_count", 64'(wr_count), 64'(0));
    check("rst_err", 64'(frame_err), 64'(0));
    nreset = 1'b1;
    tick(2);

    // Single write with exact latency: write visible on the third edge.
    nsel = 1'b0;
    tick(4);
    send_byte(8'h81);
    s0 = stb_cnt;
    spi_data = 8'hA5;
    spi_data_rdy = 1'b1;
    tick(1);
    check("lat_edge1_stb", 64'(wr_stb), 64'(0));
    tick(1);
    check("lat_edge2_stb", 64'(wr_stb), 64'(0));
    tick(1);
    check("lat_edge3_stb", 64'(wr_stb), 64'(1));
    check("lat_edge3_addr", 64'(wr_addr), 64'(1));
    tick(1);
    check("lat_edge4_stb", 64'(wr_stb), 64'(0));
    check("lat_reg1", 64'(regs[15:8]), 64'(8'hA5));
    spi_data_rdy = 1'b0;
    tick(4);
    nsel = 1'b1;
    tick(4);
    check("lat_pulses", 64'(stb_cnt - s0), 64'(1));
    check("lat_count", 64'(wr_count), 64'(1));
    model_frame(8'h81, 1, 48'h0000_0000_00A5);

    for (int v = 0; v < 6; v++) begin
      drive_frame(vecs[v].cmd, vecs[v].n, vecs[v].data, stbs);
      check($sformatf("vec%0d_regs", v), 64'(regs), 64'(vecs[v].exp_regs));
      check($sformatf("vec%0d_count", v), 64'(wr_count), 64'(vecs[v].exp_count));
      check($sformatf("vec%0d_stbs", v), 64'(stbs), 64'(vecs[v].exp_stbs));
      check($sformatf("vec%0d_err", v), 64'(frame_err), 64'(0));
    end

    for (int r = 0; r < 20; r++) begin
      cmd = 8'($urandom_range(0, 255));
      n   = $urandom_range(0, 6);
      d   = {16'($urandom), 32'($urandom)};
      drive_frame(cmd, n, d, stbs);
      check($sformatf("rnd%0d_stbs", r), 64'(stbs), 64'(cmd[7] ? n : 0));
      check($sformatf("rnd%0d_err", r), 64'(frame_err), 64'(0));
      check_model($sformatf("rnd%0d", r));
    end

    // Deselect and data strobe reach the synchronized domain together.
    s0 = stb_cnt;
    nsel = 1'b0;
    tick(4);
    send_byte(8'h80);
    spi_data = 8'h77;
    spi_data_rdy = 1'b1;
    nsel = 1'b1;
    tick(4);
    spi_data_rdy = 1'b0;
    tick(4);
    check("abort_stbs", 64'(stb_cnt - s0), 64'(0));
    check_model("abort");
    drive_frame(8'h80, 1, 48'h0000_0000_0099, stbs);
    check("abort_next_reg0", 64'(regs[7:0]), 64'(8'h99));
    check_model("abort_next");

    // Ready already high when the frame starts.
    s0 = stb_cnt;
    spi_data = 8'h81;
    spi_data_rdy = 1'b1;
    tick(4);
    nsel = 1'b0;
    tick(4);
    check("stale_err_set", 64'(frame_err), 64'(1));
    spi_data_rdy = 1'b0;
    tick(3);
    send_byte(8'h81);
    send_byte(8'h44);
    check("stale_err_hold", 64'(frame_err), 64'(1));
    nsel = 1'b1;
    tick(4);
    check("stale_err_idle", 64'(frame_err), 64'(1));
    check("stale_stbs", 64'(stb_cnt - s0), 64'(0));
    check_model("stale");
    drive_frame(8'h81, 1, 48'h0000_0000_005A, stbs);
    check("stale_next_err", 64'(frame_err), 64'(0));
    check("stale_next_stbs", 64'(stbs), 64'(1));
    check_model("stale_next");

    // Asynchronous reset while a write strobe is high, chip select held low.
    nsel = 1'b0;
    tick(4);
    send_byte(8'h82);
    spi_data = 8'hC3;
    spi_data_rdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (wr_stb) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_seen_stb", 64'(seen), 64'(1));
    #2 nreset = 1'b0;
    #1;
    check("rst_mid_regs", 64'(regs), 64'(0));
    check("rst_mid_count", 64'(wr_count), 64'(0));
    check("rst_mid_stb", 64'(wr_stb), 64'(0));
    check("rst_mid_addr", 64'(wr_addr), 64'(0));
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_count = 8'd0; m_addr = 2'd0;
    spi_data_rdy = 1'b0;
    tick(2);
    nreset = 1'b1;
    tick(4);
    send_byte(8'h82);
    send_byte(8'h3C);
    tick(2);
    nsel = 1'b1;
    tick(4);
    model_frame(8'h82, 1, 48'h0000_0000_003C);
    check("rst_resume_err", 64'(frame_err), 64'(0));
    check_model("rst_resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
